// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the MIPS inter-stage pipeline registers.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
    localparam int TNEW_W_DEF = 3;

    localparam logic [31:0] BUBBLE_PC    = 32'h0;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;
    localparam logic [31:0] BUBBLE_WD    = 32'h0;

    // Callers cast the result back to their own Tnew width.
    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_hazard_reg_fwd_query.sv
// One forwarding/stall query channel compared against the stage's registered contents.
module fwd_query
    import pipe_pkg::*;
#(
    parameter int TNEW_W = TNEW_W_DEF
) (
    input  logic                  valid,
    input  logic                  rfwr,
    input  logic [REG_ADDR_W-1:0] a3,
    input  logic [TNEW_W-1:0]     tnew,
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [TNEW_W-1:0]     tuse,
    output logic                  hit,
    output logic                  fwd,
    output logic                  stall
);

    // $zero never hits, even if a slot claims to write it.
    assign hit   = valid & rfwr & (a3 != ZERO_REG) & (a3 == addr);
    assign fwd   = hit & (tnew == '0);
    assign stall = hit & (tnew > tuse);

endmodule

// File: rtl/pipe_stage_hazard_reg.sv
// Inter-stage pipeline register with hold/flush, Tnew countdown and hazard queries.
// Optional perf counters are enabled with `define PIPE_PERF_CNT_EN.
module pipe_stage_hazard_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W         = 64,
    parameter int NUM_SRC           = 2,
    parameter int TNEW_W            = TNEW_W_DEF,
    parameter bit KEEP_PC_ON_BUBBLE = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           hold,
    input  logic                           flush,
    input  logic                           in_valid,
    input  logic [31:0]                    in_pc,
    input  logic [31:0]                    in_instr,
    input  logic [PAYLOAD_W-1:0]           in_payload,
    input  logic [REG_ADDR_W-1:0]          in_a3,
    input  logic                           in_rfwr,
    input  logic [31:0]                    in_wd,
    input  logic [TNEW_W-1:0]              in_tnew,
    output logic                           out_valid,
    output logic [31:0]                    out_pc,
    output logic [31:0]                    out_instr,
    output logic [PAYLOAD_W-1:0]           out_payload,
    output logic [REG_ADDR_W-1:0]          out_a3,
    output logic                           out_rfwr,
    output logic [31:0]                    out_wd,
    output logic [TNEW_W-1:0]              out_tnew,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  q_addr,
    input  logic [NUM_SRC*TNEW_W-1:0]      q_tuse,
    output logic [NUM_SRC-1:0]             q_hit,
    output logic [NUM_SRC-1:0]             q_fwd,
    output logic [NUM_SRC-1:0]             q_stall,
    output logic [31:0]                    bubble_cnt,
    output logic [31:0]                    hold_cnt
);

    logic              load_bubble;
    logic [TNEW_W-1:0] tnew_next;

    // An invalid input slot becomes a bubble unless the stage is frozen.
    assign load_bubble = flush | (~hold & ~in_valid);
    assign tnew_next   = TNEW_W'(sat_dec(32'(in_tnew)));

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_instr   <= '0;
            out_payload <= '0;
            out_a3      <= '0;
            out_rfwr    <= 1'b0;
            out_wd      <= '0;
            out_tnew    <= '0;
        end else if (load_bubble) begin
            out_valid   <= 1'b0;
            out_pc      <= KEEP_PC_ON_BUBBLE ? in_pc : BUBBLE_PC;
            out_instr   <= BUBBLE_INSTR;
            out_payload <= '0;
            out_a3      <= ZERO_REG;
            out_rfwr    <= 1'b0;
            out_wd      <= BUBBLE_WD;
            out_tnew    <= '0;
        end else if (!hold) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_instr   <= in_instr;
            out_payload <= in_payload;
            out_a3      <= in_a3;
            out_rfwr    <= in_rfwr;
            out_wd      <= in_wd;
            out_tnew    <= tnew_next;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] hold_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            if (load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (hold && !flush) hold_cnt_q <= hold_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign hold_cnt   = hold_cnt_q;
`else
    assign bubble_cnt = '0;
    assign hold_cnt   = '0;
`endif

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_query
        fwd_query #(
            .TNEW_W (TNEW_W)
        ) u_query (
            .valid (out_valid),
            .rfwr  (out_rfwr),
            .a3    (out_a3),
            .tnew  (out_tnew),
            .addr  (q_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .tuse  (q_tuse[i*TNEW_W +: TNEW_W]),
            .hit   (q_hit[i]),
            .fwd   (q_fwd[i]),
            .stall (q_stall[i])
        );
    end

endmodule

// File: tb/tb_pipe_stage_hazard_reg.sv
// Self-checking bench: vector table, directed corner sequences and randomized model comparison.
module tb_pipe_stage_hazard_reg;

    logic        clk = 1'b0;
    logic        reset, hold, flush, in_valid, in_rfwr;
    logic [31:0] in_pc, in_instr, in_wd;
    logic [63:0] in_payload;
    logic [4:0]  in_a3;
    logic [2:0]  in_tnew;
    logic [9:0]  qa;
    logic [5:0]  qt;
    logic [14:0] qa3;
    logic [8:0]  qt3;

    logic        o_valid, o_rfwr;
    logic [31:0] o_pc, o_instr, o_wd, o_bcnt, o_hcnt;
    logic [63:0] o_payload;
    logic [4:0]  o_a3;
    logic [2:0]  o_tnew;
    logic [1:0]  o_hit, o_fwd, o_stall;

    logic        p_valid, p_rfwr;
    logic [31:0] p_pc, p_instr, p_wd, p_bcnt, p_hcnt;
    logic [63:0] p_payload;
    logic [4:0]  p_a3;
    logic [2:0]  p_tnew;
    logic [2:0]  p_hit, p_fwd, p_stall;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pipe_stage_hazard_reg #(.PAYLOAD_W(64), .NUM_SRC(2), .TNEW_W(3), .KEEP_PC_ON_BUBBLE(1'b0)) u_dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr(in_instr), .in_payload(in_payload), .in_a3(in_a3),
        .in_rfwr(in_rfwr), .in_wd(in_wd), .in_tnew(in_tnew),
        .out_valid(o_valid), .out_pc(o_pc), .out_instr(o_instr), .out_payload(o_payload),
        .out_a3(o_a3), .out_rfwr(o_rfwr), .out_wd(o_wd), .out_tnew(o_tnew),
        .q_addr(qa), .q_tuse(qt), .q_hit(o_hit), .q_fwd(o_fwd), .q_stall(o_stall),
        .bubble_cnt(o_bcnt), .hold_cnt(o_hcnt)
    );

    pipe_stage_hazard_reg #(.PAYLOAD_W(64), .NUM_SRC(3), .TNEW_W(3), .KEEP_PC_ON_BUBBLE(1'b1)) u_dut3 (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr(in_instr), .in_payload(in_payload), .in_a3(in_a3),
        .in_rfwr(in_rfwr), .in_wd(in_wd), .in_tnew(in_tnew),
        .out_valid(p_valid), .out_pc(p_pc), .out_instr(p_instr), .out_payload(p_payload),
        .out_a3(p_a3), .out_rfwr(p_rfwr), .out_wd(p_wd), .out_tnew(p_tnew),
        .q_addr(qa3), .q_tuse(qt3), .q_hit(p_hit), .q_fwd(p_fwd), .q_stall(p_stall),
        .bubble_cnt(p_bcnt), .hold_cnt(p_hcnt)
    );

    // Reference model of the stage contents
    logic        m_valid, m_rfwr;
    logic [31:0] m_pc, m_pc3, m_instr, m_wd, m_bcnt, m_hcnt;
    logic [63:0] m_payload;
    logic [4:0]  m_a3;
    logic [2:0]  m_tnew;

    task automatic model_edge();
        if (reset) begin
            {m_valid, m_rfwr, m_pc, m_pc3, m_instr, m_wd, m_payload, m_a3, m_tnew} = '0;
            m_bcnt = 0;
            m_hcnt = 0;
        end else if (flush || (!hold && !in_valid)) begin
            {m_valid, m_rfwr, m_instr, m_wd, m_payload, m_a3, m_tnew} = '0;
            m_pc  = 32'h0;
            m_pc3 = in_pc;
            m_bcnt = m_bcnt + 1;
        end else if (hold) begin
            m_hcnt = m_hcnt + 1;
        end else begin
            m_valid = 1'b1;
            m_pc = in_pc;
            m_pc3 = in_pc;
            m_instr = in_instr;
            m_payload = in_payload;
            m_a3 = in_a3;
            m_rfwr = in_rfwr;
            m_wd = in_wd;
            m_tnew = (in_tnew == 3'd0) ? 3'd0 : in_tnew - 3'd1;
        end
    endtask

    // Returns {stall, fwd, hit}
    function automatic logic [2:0] qref(input logic [4:0] addr, input logic [2:0] tuse);
        logic h;
        h = m_valid && m_rfwr && (m_a3 != 5'd0) && (m_a3 == addr);
        return {h && (m_tnew > tuse), h && (m_tnew == 3'd0), h};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        logic [31:0] eb, eh;
`ifdef PIPE_PERF_CNT_EN
        eb = m_bcnt;
        eh = m_hcnt;
`else
        eb = 32'h0;
        eh = 32'h0;
`endif
        chk("valid", o_valid, m_valid);
        chk("pc", o_pc, m_pc);
        chk("instr", o_instr, m_instr);
        chk("payload", o_payload, m_payload);
        chk("a3", o_a3, m_a3);
        chk("rfwr", o_rfwr, m_rfwr);
        chk("wd", o_wd, m_wd);
        chk("tnew", o_tnew, m_tnew);
        chk("bubble_cnt", o_bcnt, eb);
        chk("hold_cnt", o_hcnt, eh);
        chk("valid3", p_valid, m_valid);
        chk("pc3", p_pc, m_pc3);
        chk("a3_3", p_a3, m_a3);
        chk("tnew3", p_tnew, m_tnew);
        chk("wd3", p_wd, m_wd);
        chk("bubble_cnt3", p_bcnt, eb);
        for (int c = 0; c < 2; c++)
            chk($sformatf("query%0d", c), {o_stall[c], o_fwd[c], o_hit[c]}, qref(qa[c*5 +: 5], qt[c*3 +: 3]));
        for (int c = 0; c < 3; c++)
            chk($sformatf("query3_%0d", c), {p_stall[c], p_fwd[c], p_hit[c]}, qref(qa3[c*5 +: 5], qt3[c*3 +: 3]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_state();
    endtask

    task automatic set_in(input logic r, input logic h, input logic f, input logic v, input logic [31:0] pc,
                          input logic [4:0] a3, input logic rf, input logic [31:0] wd, input logic [2:0] tn);
        reset = r; hold = h; flush = f; in_valid = v; in_pc = pc;
        in_a3 = a3; in_rfwr = rf; in_wd = wd; in_tnew = tn;
        in_instr = $urandom;
        in_payload = {$urandom, $urandom};
    endtask

    typedef struct {
        logic rst, hld, fls, vld;
        logic [31:0] pc;
        logic [4:0] a3;
        logic rf;
        logic [31:0] wd;
        logic [2:0] tn;
        logic [4:0] qadr;
        logic [2:0] qtu;
        logic e_valid;
        logic [2:0] e_tnew;
        logic e_hit, e_fwd, e_stall;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    5'd0, 1'b0, 32'h0,    3'd0, 5'd8, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 5'd8, 1'b1, 32'h55,   3'd0, 5'd8, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3004, 5'd5, 1'b1, 32'h1234, 3'd2, 5'd5, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3004, 5'd5, 1'b1, 32'h1234, 3'd1, 5'd5, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3008, 5'd5, 1'b1, 32'h1,    3'd7, 5'd5, 3'd6, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h300c, 5'd5, 1'b1, 32'h2,    3'd7, 5'd5, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3010, 5'd0, 1'b1, 32'h3,    3'd0, 5'd0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h3014, 5'd5, 1'b1, 32'h4,    3'd3, 5'd5, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3018, 5'd5, 1'b0, 32'h5,    3'd0, 5'd5, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h301c, 5'd5, 1'b1, 32'h6,    3'd0, 5'd6, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};

        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 3'd0);
        qa = '0; qt = '0; qa3 = '0; qt3 = '0;

        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].rst, vecs[i].hld, vecs[i].fls, vecs[i].vld, vecs[i].pc,
                   vecs[i].a3, vecs[i].rf, vecs[i].wd, vecs[i].tn);
            qa = {5'd0, vecs[i].qadr};
            qt = {3'd0, vecs[i].qtu};
            tick();
            chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_tnew", i), o_tnew, vecs[i].e_tnew);
            chk($sformatf("vec%0d_hit", i), o_hit[0], vecs[i].e_hit);
            chk($sformatf("vec%0d_fwd", i), o_fwd[0], vecs[i].e_fwd);
            chk($sformatf("vec%0d_stall", i), o_stall[0], vecs[i].e_stall);
        end

        // Reset mid-stream
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 5'd8, 1'b1, 32'h77, 3'd3);
        qa = {5'd8, 5'd8};
        tick();
        chk("mid_hit_before_reset", o_hit, 2'b11);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h3000, 5'd8, 1'b1, 32'h77, 3'd3);
        tick();
        chk("mid_reset_pc", o_pc, 32'h0);
        chk("mid_reset_a3", o_a3, 5'd0);
        chk("mid_reset_rfwr", o_rfwr, 1'b0);
        chk("mid_reset_hit", o_hit, 2'b00);

        // Hold for three cycles
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h3004, 5'd4, 1'b1, 32'hbeef, 3'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h4000 + i, 5'd9, 1'b1, 32'h1, 3'd5);
            tick();
            chk("hold_pc", o_pc, 32'h3004);
            chk("hold_tnew", o_tnew, 3'd1);
        end
`ifdef PIPE_PERF_CNT_EN
        chk("hold_cnt_3", o_hcnt, 32'd3);
`endif

        // Flush beats hold
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h3008, 5'd4, 1'b1, 32'h1, 3'd1);
        tick();
        chk("flush_valid", o_valid, 1'b0);
        chk("flush_rfwr", o_rfwr, 1'b0);
        chk("flush_pc_drop", o_pc, 32'h0);
        chk("flush_pc_keep", p_pc, 32'h3008);
`ifdef PIPE_PERF_CNT_EN
        chk("flush_bubble_cnt", o_bcnt, 32'd1);
        chk("flush_hold_cnt", o_hcnt, 32'd3);
`endif

        // Zero-register filter
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h300c, 5'd0, 1'b1, 32'h9, 3'd0);
        qa = '0; qt = '0;
        tick();
        chk("zero_hit", o_hit, 2'b00);
        chk("zero_fwd", o_fwd, 2'b00);
        chk("zero_stall", o_stall, 2'b00);

        // Three-channel query
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h3010, 5'd9, 1'b1, 32'ha, 3'd3);
        qa3 = {5'd10, 5'd9, 5'd9};
        qt3 = {3'd0, 3'd1, 3'd2};
        tick();
        chk("q3_stall", p_stall, 3'b010);
        chk("q3_hit", p_hit, 3'b011);
        chk("q3_fwd", p_fwd, 3'b000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                   $urandom_range(0, 99) < 80, $urandom, 5'($urandom_range(0, 7)), 1'($urandom),
                   $urandom, 3'($urandom));
            for (int c = 0; c < 2; c++) begin
                qa[c*5 +: 5] = 5'($urandom_range(0, 7));
                qt[c*3 +: 3] = 3'($urandom);
            end
            for (int c = 0; c < 3; c++) begin
                qa3[c*5 +: 5] = 5'($urandom_range(0, 7));
                qt3[c*3 +: 3] = 3'($urandom);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
